// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: packs a length-prefixed, XOR-checksummed
// byte stream into big-endian 32-bit words and holds the CPU until the image is verified.
module imem_loader #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_PAYLOAD,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] MAX_WORDS = 17'(MEM_BYTES / 4);

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [23:0]         word_q, word_d;
    logic [1:0]          idx_q, idx_d;
    logic [7:0]          csum_q, csum_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [15:0]         words_q, words_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic [15:0]         len_full;
    logic [15:0]         words_inc;
    logic                xfer;

    assign in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_PAYLOAD) || (state_q == S_CHECK);
    assign xfer      = in_valid && in_ready;
    assign len_full  = {len_q[15:8], in_data};
    assign words_inc = words_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_d      = word_q;
        idx_d       = idx_q;
        csum_d      = csum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        words_d     = words_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN_HI;
                    words_d = 16'd0;
                    csum_d  = 8'd0;
                    idx_d   = 2'd0;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = in_data;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d = len_full;
                    if ({1'b0, len_full} > MAX_WORDS)
                        state_d = S_ERR;
                    else if (len_full == 16'd0)
                        state_d = S_CHECK;
                    else
                        state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (xfer) begin
                    csum_d = csum_q ^ in_data;
                    word_d = {word_q[15:0], in_data};
                    idx_d  = idx_q + 2'd1;
                    // Fourth byte completes a word; it is written on the next cycle.
                    if (idx_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {words_q[ADDR_W-3:0], 2'b00};
                        mem_wdata_d = {word_q, in_data};
                        words_d     = words_inc;
                        if (words_inc == len_q)
                            state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (xfer)
                    state_d = (in_data == csum_q) ? S_DONE : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase

        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERR);
        cpu_hold_d = (state_d != S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            word_q      <= '0;
            idx_q       <= '0;
            csum_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            words_q     <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_hold_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_q      <= word_d;
            idx_q       <= idx_d;
            csum_q      <= csum_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            words_q     <= words_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cpu_hold_q  <= cpu_hold_d;
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign words_loaded = words_q;
    assign done         = done_q;
    assign error        = error_q;
    assign cpu_hold     = cpu_hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: streams hand-built images and checks the
// resulting memory writes and status flags against hand-computed values.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int n_checks = 0;
    int n_pass   = 0;

    logic [9:0]  wr_addr[$];
    logic [31:0] wr_data[$];

    imem_loader #(.MEM_BYTES(1024), .ADDR_W(10)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Every cycle with mem_we high is logged, so a stretched pulse shows up as an extra write.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected)
            n_pass++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checkOutput("ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] s[$], input int toggle, input int gap_at, input int last);
        for (int i = 0; i < s.size(); i++) begin
            if (i == gap_at) begin
                @(negedge clk);
                in_valid = 1'b0;
                repeat (4) @(negedge clk);
            end
            sendByte(s[i]);
            if (toggle != 0) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
        end
        if (last != 0) begin
            @(negedge clk);
            in_valid = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic checkLoad(input string tag, input logic exp_done, input logic exp_err,
                             input int exp_words, input int exp_writes);
        checkOutput({tag, "_done"}, 32'(done), 32'(exp_done));
        checkOutput({tag, "_error"}, 32'(error), 32'(exp_err));
        checkOutput({tag, "_hold"}, 32'(cpu_hold), 32'(!exp_done));
        checkOutput({tag, "_ready"}, 32'(in_ready), 32'd0);
        checkOutput({tag, "_words"}, 32'(words_loaded), 32'(exp_words));
        checkOutput({tag, "_nwrites"}, 32'(wr_addr.size()), 32'(exp_writes));
    endtask

    task automatic checkTwoWords(input string tag);
        if (wr_addr.size() >= 2) begin
            checkOutput({tag, "_addr0"}, 32'(wr_addr[0]), 32'h0);
            checkOutput({tag, "_data0"}, wr_data[0], 32'h20080005);
            checkOutput({tag, "_addr1"}, 32'(wr_addr[1]), 32'h4);
            checkOutput({tag, "_data1"}, wr_data[1], 32'h00000020);
        end
    endtask

    task automatic clearLog();
        wr_addr.delete();
        wr_data.delete();
    endtask

    logic [7:0] good[$];
    logic [7:0] bad[$];
    logic [7:0] partial[$];

    initial begin
        // Payload XOR: 20^08^00^05^00^00^00^20 = 0x0D
        good    = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h20, 8'h0D};
        bad     = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h20, 8'h24};
        partial = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00};

        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_we", 32'(mem_we), 32'd0);
        checkOutput("rst_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_wdata", mem_wdata, 32'd0);
        checkOutput("rst_hold", 32'(cpu_hold), 32'd1);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_error", 32'(error), 32'd0);
        checkOutput("rst_words", 32'(words_loaded), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_ready", 32'(in_ready), 32'd0);

        clearLog();
        pulseStart();
        applyStimulus(good, 0, -1, 1);
        checkLoad("good", 1'b1, 1'b0, 2, 2);
        checkTwoWords("good");

        clearLog();
        pulseStart();
        checkOutput("restart_hold", 32'(cpu_hold), 32'd1);
        checkOutput("restart_done", 32'(done), 32'd0);
        applyStimulus(bad, 0, -1, 1);
        checkLoad("badsum", 1'b0, 1'b1, 2, 2);
        checkTwoWords("badsum");

        clearLog();
        pulseStart();
        applyStimulus('{8'h01, 8'h01}, 0, -1, 1);
        checkLoad("toolong", 1'b0, 1'b1, 0, 0);

        clearLog();
        pulseStart();
        applyStimulus('{8'h00, 8'h00, 8'h00}, 0, -1, 1);
        checkLoad("empty_ok", 1'b1, 1'b0, 0, 0);

        clearLog();
        pulseStart();
        applyStimulus('{8'h00, 8'h00, 8'h5A}, 0, -1, 1);
        checkLoad("empty_bad", 1'b0, 1'b1, 0, 0);

        clearLog();
        pulseStart();
        applyStimulus(good, 1, 4, 1);
        checkLoad("gapped", 1'b1, 1'b0, 2, 2);
        checkTwoWords("gapped");

        clearLog();
        pulseStart();
        applyStimulus(partial, 0, -1, 0);
        #3;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("midrst_hold", 32'(cpu_hold), 32'd1);
        checkOutput("midrst_ready", 32'(in_ready), 32'd0);
        checkOutput("midrst_we", 32'(mem_we), 32'd0);
        checkOutput("midrst_addr", 32'(mem_addr), 32'd0);
        checkOutput("midrst_wdata", mem_wdata, 32'd0);
        checkOutput("midrst_words", 32'(words_loaded), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_error", 32'(error), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clearLog();
        pulseStart();
        applyStimulus(good, 0, -1, 1);
        checkLoad("after_rst", 1'b1, 1'b0, 2, 2);
        checkTwoWords("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
